// File: rtl/isu_if.sv
`default_nettype none
// ============================================================================
// Module : isu_if
// Brief  : Decoder <-> instruction staging unit bus bundle.
// Rev    : 1.0
// ============================================================================
interface isu_if;
  logic [7:0] bus;
  logic       ir_we;
  logic [3:0] pc;     // {pc_oe, pc_cub, pc_ini, pc_lrc}
  logic [1:0] len;
  logic [7:0] insn;
  logic [7:0] d1;
  logic [7:0] d2;
  logic [7:0] d3;
  logic [2:0] is;
  logic [2:0] fp;
  logic       rdy;
  logic       fault;

  modport master (
    output bus, ir_we, pc, len,
    input  insn, d1, d2, d3, is, fp, rdy, fault
  );

  modport slave (
    input  bus, ir_we, pc, len,
    output insn, d1, d2, d3, is, fp, rdy, fault
  );
endinterface
`default_nettype wire

// File: rtl/isu.sv
`default_nettype none
// ============================================================================
// Module : isu
// Brief  : Instruction staging unit; assembles opcode + operands, owns step.
// Rev    : 1.0
// ============================================================================
module isu #(
  parameter int unsigned STEP_MAX = 7
) (
  input  wire logic clk,
  input  wire logic rst,
  isu_if.slave      bif
);
  localparam logic [2:0] c_step_max = 3'(STEP_MAX);
  localparam logic [2:0] c_fp_full  = 3'd4;

  logic [7:0] insn_q, insn_d;
  logic [7:0] d1_q, d1_d;
  logic [7:0] d2_q, d2_d;
  logic [7:0] d3_q, d3_d;
  logic [2:0] is_q, is_d;
  logic [2:0] fp_q, fp_d;
  logic       fault_q, fault_d;

  logic       w_restart;
  logic       w_step;
  logic [2:0] w_fp_base;
  logic       w_pc_oe_unused;

  assign w_restart      = bif.pc[0] | bif.pc[1];
  assign w_step         = bif.pc[2];
  assign w_pc_oe_unused = bif.pc[3];

  always_comb begin
    insn_d    = insn_q;
    d1_d      = d1_q;
    d2_d      = d2_q;
    d3_d      = d3_q;
    is_d      = is_q;
    fault_d   = fault_q;
    w_fp_base = fp_q;

    if (w_restart) begin
      is_d      = 3'd0;
      w_fp_base = 3'd0;
      insn_d    = 8'h00;
      d1_d      = 8'h00;
      d2_d      = 8'h00;
      d3_d      = 8'h00;
    end else if (w_step) begin
      if (is_q < c_step_max) begin
        is_d = is_q + 3'd1;
      end else begin
        is_d    = 3'd0;
        fault_d = 1'b1;
      end
    end

    // Capture indexes from the post-restart pointer so restart+write lands in insn.
    fp_d = w_fp_base;
    if (bif.ir_we) begin
      if (w_fp_base < c_fp_full) begin
        case (w_fp_base[1:0])
          2'd0:    insn_d = bif.bus;
          2'd1:    d1_d   = bif.bus;
          2'd2:    d2_d   = bif.bus;
          default: d3_d   = bif.bus;
        endcase
        fp_d = w_fp_base + 3'd1;
      end else begin
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      insn_q  <= 8'h00;
      d1_q    <= 8'h00;
      d2_q    <= 8'h00;
      d3_q    <= 8'h00;
      is_q    <= 3'd0;
      fp_q    <= 3'd0;
      fault_q <= 1'b0;
    end else begin
      insn_q  <= insn_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      is_q    <= is_d;
      fp_q    <= fp_d;
      fault_q <= fault_d;
    end
  end

  assign bif.insn  = insn_q;
  assign bif.d1    = d1_q;
  assign bif.d2    = d2_q;
  assign bif.d3    = d3_q;
  assign bif.is    = is_q;
  assign bif.fp    = fp_q;
  assign bif.fault = fault_q;
  // fp==0 yields rdy=0 for any len since 0 > len never holds.
  assign bif.rdy   = (fp_q > {1'b0, bif.len});
endmodule
`default_nettype wire

// File: tb/tb_isu.sv
`default_nettype none
// ============================================================================
// Module : tb_isu
// Brief  : Table-driven, scoreboarded bench for isu.
// Rev    : 1.0
// ============================================================================
module tb_isu;
  localparam logic [3:0] c_pc_idle = 4'b0000;
  localparam logic [3:0] c_pc_lrc  = 4'b0001;
  localparam logic [3:0] c_pc_ini  = 4'b0010;
  localparam logic [3:0] c_pc_cub  = 4'b0100;
  localparam logic [3:0] c_pc_oe   = 4'b1000;

  typedef struct {
    string      name;
    logic       rst;
    logic       ir_we;
    logic [3:0] pc;
    logic [7:0] bus;
    logic [1:0] len;
    logic [7:0] e_insn;
    logic [7:0] e_d1;
    logic [7:0] e_d2;
    logic [7:0] e_d3;
    logic [2:0] e_is;
    logic [2:0] e_fp;
    logic       e_rdy;
    logic       e_fault;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  isu_if u_if ();

  isu #(.STEP_MAX(7)) u_dut (
    .clk (clk),
    .rst (rst),
    .bif (u_if.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input logic r, input logic we,
                              input logic [3:0] pc, input logic [7:0] bus,
                              input logic [1:0] len, input logic [7:0] insn,
                              input logic [7:0] d1, input logic [7:0] d2,
                              input logic [7:0] d3, input logic [2:0] is_v,
                              input logic [2:0] fp, input logic rdy,
                              input logic fault);
    vec_t v;
    v.name = name; v.rst = r; v.ir_we = we; v.pc = pc; v.bus = bus; v.len = len;
    v.e_insn = insn; v.e_d1 = d1; v.e_d2 = d2; v.e_d3 = d3;
    v.e_is = is_v; v.e_fp = fp; v.e_rdy = rdy; v.e_fault = fault;
    return v;
  endfunction

  task automatic cmp(input string name, input string field,
                     input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h", name, field, got, want);
    end
  endtask

  // Drive one cycle, push its expectation, then pop and compare after the edge.
  task automatic apply(input vec_t v_in);
    vec_t v;
    vec_t e;
    v = v_in;
    if (v.rst) begin
      v.bus   = 8'($urandom);
      v.ir_we = 1'($urandom);
      v.pc    = 4'($urandom);
    end
    rst       = v.rst;
    u_if.bus   = v.bus;
    u_if.ir_we = v.ir_we;
    u_if.pc    = v.pc;
    u_if.len   = v.len;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    cmp(e.name, "insn",  u_if.insn,  e.e_insn);
    cmp(e.name, "d1",    u_if.d1,    e.e_d1);
    cmp(e.name, "d2",    u_if.d2,    e.e_d2);
    cmp(e.name, "d3",    u_if.d3,    e.e_d3);
    cmp(e.name, "is",    {5'd0, u_if.is}, {5'd0, e.e_is});
    cmp(e.name, "fp",    {5'd0, u_if.fp}, {5'd0, e.e_fp});
    cmp(e.name, "rdy",   {7'd0, u_if.rdy},   {7'd0, e.e_rdy});
    cmp(e.name, "fault", {7'd0, u_if.fault}, {7'd0, e.e_fault});
  endtask

  initial begin
    u_if.bus = 8'h00; u_if.ir_we = 1'b0; u_if.pc = 4'h0; u_if.len = 2'd0;

    //               name      rst we  pc                    bus    len insn   d1     d2     d3     is    fp    rdy   flt
    tbl.push_back(mk("rst0",   1, 0, c_pc_idle,             8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk("rst1",   1, 0, c_pc_idle,             8'h00, 3, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk("rst2",   1, 0, c_pc_idle,             8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk("fch_rs", 0, 0, c_pc_lrc,              8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk("fch_b0", 0, 1, c_pc_idle,             8'hA5, 2, 8'hA5, 8'h00, 8'h00, 8'h00, 3'd0, 3'd1, 1'b0, 1'b0));
    tbl.push_back(mk("fch_b1", 0, 1, c_pc_idle,             8'h12, 2, 8'hA5, 8'h12, 8'h00, 8'h00, 3'd0, 3'd2, 1'b0, 1'b0));
    tbl.push_back(mk("fch_b2", 0, 1, c_pc_idle,             8'h34, 2, 8'hA5, 8'h12, 8'h34, 8'h00, 3'd0, 3'd3, 1'b1, 1'b0));
    tbl.push_back(mk("oe_ign", 0, 0, c_pc_oe,               8'hFF, 2, 8'hA5, 8'h12, 8'h34, 8'h00, 3'd0, 3'd3, 1'b1, 1'b0));
    tbl.push_back(mk("stp1",   0, 0, c_pc_cub,              8'h00, 2, 8'hA5, 8'h12, 8'h34, 8'h00, 3'd1, 3'd3, 1'b1, 1'b0));
    tbl.push_back(mk("stp2",   0, 0, c_pc_cub,              8'h00, 2, 8'hA5, 8'h12, 8'h34, 8'h00, 3'd2, 3'd3, 1'b1, 1'b0));
    tbl.push_back(mk("stp3",   0, 0, c_pc_cub,              8'h00, 2, 8'hA5, 8'h12, 8'h34, 8'h00, 3'd3, 3'd3, 1'b1, 1'b0));
    tbl.push_back(mk("stp4",   0, 0, c_pc_cub,              8'h00, 2, 8'hA5, 8'h12, 8'h34, 8'h00, 3'd4, 3'd3, 1'b1, 1'b0));
    tbl.push_back(mk("stp5",   0, 0, c_pc_cub,              8'h00, 2, 8'hA5, 8'h12, 8'h34, 8'h00, 3'd5, 3'd3, 1'b1, 1'b0));
    tbl.push_back(mk("simul",  0, 1, c_pc_ini | c_pc_cub,   8'h7E, 0, 8'h7E, 8'h00, 8'h00, 8'h00, 3'd0, 3'd1, 1'b1, 1'b0));
    tbl.push_back(mk("ovf_rs", 0, 0, c_pc_lrc,              8'h00, 3, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk("ovf_1",  0, 1, c_pc_idle,             8'h11, 3, 8'h11, 8'h00, 8'h00, 8'h00, 3'd0, 3'd1, 1'b0, 1'b0));
    tbl.push_back(mk("ovf_2",  0, 1, c_pc_idle,             8'h22, 3, 8'h11, 8'h22, 8'h00, 8'h00, 3'd0, 3'd2, 1'b0, 1'b0));
    tbl.push_back(mk("ovf_3",  0, 1, c_pc_idle,             8'h33, 3, 8'h11, 8'h22, 8'h33, 8'h00, 3'd0, 3'd3, 1'b0, 1'b0));
    tbl.push_back(mk("ovf_4",  0, 1, c_pc_idle,             8'h44, 3, 8'h11, 8'h22, 8'h33, 8'h44, 3'd0, 3'd4, 1'b1, 1'b0));
    tbl.push_back(mk("ovf_5",  0, 1, c_pc_idle,             8'h55, 3, 8'h11, 8'h22, 8'h33, 8'h44, 3'd0, 3'd4, 1'b1, 1'b1));
    tbl.push_back(mk("rs_all", 0, 0, c_pc_lrc | c_pc_ini | c_pc_cub, 8'h00, 3,
                                                              8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b1));
    tbl.push_back(mk("flt_cl", 1, 0, c_pc_idle,             8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk("sil_1",  0, 1, c_pc_idle,             8'hAA, 0, 8'hAA, 8'h00, 8'h00, 8'h00, 3'd0, 3'd1, 1'b1, 1'b0));
    tbl.push_back(mk("sil_2",  0, 1, c_pc_idle,             8'hBB, 0, 8'hAA, 8'hBB, 8'h00, 8'h00, 3'd0, 3'd2, 1'b1, 1'b0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Step wrap: 8 steps from is=0, fault sets on the wrapping edge and sticks.
    apply(mk("wr_rst", 1, 0, c_pc_idle, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0));
    for (int i = 0; i < 8; i++) begin
      apply(mk($sformatf("wrap%0d", i), 0, 0, c_pc_cub, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00,
               3'((i + 1) % 8), 3'd0, 1'b0, (i == 7) ? 1'b1 : 1'b0));
    end
    apply(mk("wr_hold", 0, 0, c_pc_idle, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b1));

    // Reset mid-fill: partial operands are discarded and the reset-cycle write is lost.
    apply(mk("mf_rs",  0, 0, c_pc_ini,  8'h00, 3, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b1));
    apply(mk("mf_b0",  0, 1, c_pc_idle, 8'h01, 3, 8'h01, 8'h00, 8'h00, 8'h00, 3'd0, 3'd1, 1'b0, 1'b1));
    apply(mk("mf_b1",  0, 1, c_pc_idle, 8'h02, 3, 8'h01, 8'h02, 8'h00, 8'h00, 3'd0, 3'd2, 1'b0, 1'b1));
    rst = 1'b1; u_if.ir_we = 1'b1; u_if.bus = 8'h03; u_if.pc = c_pc_idle; u_if.len = 2'd3;
    exp_q.push_back(mk("mf_rst", 1, 1, c_pc_idle, 8'h03, 3, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    begin
      vec_t e;
      e = exp_q.pop_front();
      cmp(e.name, "insn",  u_if.insn, e.e_insn);
      cmp(e.name, "d1",    u_if.d1,   e.e_d1);
      cmp(e.name, "fp",    {5'd0, u_if.fp}, {5'd0, e.e_fp});
      cmp(e.name, "fault", {7'd0, u_if.fault}, {7'd0, e.e_fault});
    end
    apply(mk("mf_idle", 0, 0, c_pc_idle, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0));
    apply(mk("mf_new",  0, 1, c_pc_idle, 8'h09, 0, 8'h09, 8'h00, 8'h00, 8'h00, 3'd0, 3'd1, 1'b1, 1'b0));

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain left=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
